// File: rtl/bram_pkg.sv
// Shared constants for the single-port BRAM block: FSM state encoding and default sizes.
package bram_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MEM_SIZE   = 2**12 - 1;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/bram_sp_resp_if.sv
// Request/response bus of the single-port BRAM: the requester drives address,
// enables and write data, the memory returns read data.
interface bram_sp_resp_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  en;
    logic                  we;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] qout;

    modport master (
        output addr,
        output en,
        output we,
        output din,
        input  qout
    );

    modport slave (
        input  addr,
        input  en,
        input  we,
        input  din,
        output qout
    );

endinterface

// File: rtl/bram_sp_core.sv
// Storage array with one synchronous write/read port; deliberately reset-free so
// synthesis maps it onto block RAM.
module bram_sp_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4095,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        if (i_re) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/bram_sp_resp.sv
// Single-port BRAM wrapper: zero-fills the array after reset, validates requests,
// counts accepted accesses and offers a one- or two-cycle read latency.
module bram_sp_resp
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_sp_resp_if.slave        bus,
    input  logic                 i_clr,
    output logic                 o_ready,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_wr_cnt,
    output logic [CNT_WIDTH-1:0] o_rd_cnt
);

    // The state register carries a spare MSB; any code with it set falls back to INIT.
    localparam logic [1:0] S_INIT  = {1'b0, ST_INIT};
    localparam logic [1:0] S_READY = {1'b0, ST_READY};

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;
    logic [CNT_WIDTH-1:0]  r_rd_cnt;
    logic                  r_vld_p1;
    logic                  r_bad_p1;
    logic [DATA_WIDTH-1:0] r_q_p2;

    logic                  w_init;
    logic                  w_ready;
    logic                  w_in_range;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic                  w_bad_rd;
    logic                  w_req_err;
    logic                  w_core_we;
    logic [ADDR_WIDTH-1:0] w_core_addr;
    logic [DATA_WIDTH-1:0] w_core_din;
    logic [DATA_WIDTH-1:0] w_core_dout;
    logic [DATA_WIDTH-1:0] w_q_p1;

    assign w_init     = (r_state == S_INIT);
    assign w_ready    = (r_state == S_READY);
    assign w_in_range = ({1'b0, bus.addr} < ADDR_LIMIT);

    assign w_acc_wr  = bus.en &  bus.we & w_ready &  w_in_range;
    assign w_acc_rd  = bus.en & ~bus.we & w_ready &  w_in_range;
    assign w_bad_rd  = bus.en & ~bus.we & w_ready & ~w_in_range;
    assign w_req_err = bus.en & (~w_ready | ~w_in_range);

    // During INIT the port belongs to the zero-fill sweep; user requests are ignored.
    assign w_core_we   = w_init | w_acc_wr;
    assign w_core_addr = w_init ? r_init_ptr : bus.addr;
    assign w_core_din  = w_init ? '0 : bus.din;

    bram_sp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk    (clk),
        .i_we   (w_core_we),
        .i_re   (w_acc_rd),
        .i_addr (w_core_addr),
        .i_din  (w_core_din),
        .o_dout (w_core_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_init_ptr <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_ptr == LAST_PTR) begin
                        r_state <= S_READY;
                    end else begin
                        r_init_ptr <= r_init_ptr + 1'b1;
                    end
                end
                S_READY: r_state <= S_READY;
                default: begin
                    r_state    <= S_INIT;
                    r_init_ptr <= '0;
                end
            endcase
        end
    end

    // Clear has priority over any increment or error raised in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err    <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (i_clr) begin
            r_err    <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_req_err) begin
                r_err <= 1'b1;
            end
            if (w_acc_wr) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end
            if (w_acc_rd) begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end
        end
    end

    // Stage p1: array output register is live; out-of-range reads return zero, else hold.
    assign w_q_p1 = r_vld_p1 ? w_core_dout :
                    r_bad_p1 ? '0          : r_q_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_bad_p1 <= 1'b0;
            r_q_p2   <= '0;
        end else begin
            r_vld_p1 <= w_acc_rd;
            r_bad_p1 <= w_bad_rd;
            r_q_p2   <= w_q_p1;
        end
    end

    // Stage p2: r_q_p2 doubles as the hold register and the optional extra output stage.
    assign bus.qout = (RD_LATENCY == 2) ? r_q_p2 : w_q_p1;

    assign o_ready  = w_ready;
    assign o_err    = r_err;
    assign o_wr_cnt = r_wr_cnt;
    assign o_rd_cnt = r_rd_cnt;

endmodule

// File: tb/tb_bram_sp_resp.sv
// Bench for bram_sp_resp: three instances (latency 1, latency 2, narrow counters)
// driven in lockstep, read data checked against a latency-aware scoreboard.
module tb_bram_sp_resp;
    import bram_pkg::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int MS  = DEF_MEM_SIZE;
    localparam int AW  = $clog2(MS);
    localparam int CW  = DEF_CNT_WIDTH;
    localparam int CW3 = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic i_clr = 1'b0;

    logic           rdy1, rdy2, rdy3;
    logic           err1, err2, err3;
    logic [CW-1:0]  wc1, rc1, wc2, rc2;
    logic [CW3-1:0] wc3, rc3;

    always #5 clk = ~clk;

    bram_sp_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
    bram_sp_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();
    bram_sp_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

    bram_sp_resp #(.RD_LATENCY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .i_clr(i_clr),
        .o_ready(rdy1), .o_err(err1), .o_wr_cnt(wc1), .o_rd_cnt(rc1)
    );
    bram_sp_resp #(.RD_LATENCY(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .i_clr(i_clr),
        .o_ready(rdy2), .o_err(err2), .o_wr_cnt(wc2), .o_rd_cnt(rc2)
    );
    bram_sp_resp #(.RD_LATENCY(1), .CNT_WIDTH(CW3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .i_clr(i_clr),
        .o_ready(rdy3), .o_err(err3), .o_wr_cnt(wc3), .o_rd_cnt(rc3)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] val;
    } exp_t;

    typedef struct {
        bit            we;
        int            addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_q;
    } vec_t;

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t sb3[$];
    vec_t vt[8];

    logic [DW-1:0] m_mem [MS];
    bit  m_err   = 1'b0;
    int  m_wr    = 0;
    int  m_rd    = 0;
    int  cyc     = 0;
    int  rdy_cyc = 1 << 30;
    int  n_cmp   = 0;
    int  n_bad   = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb1.size() > 0 && sb1[0].due <= cyc) begin
            e = sb1.pop_front();
            chk("qout_L1", if1.qout, e.val);
        end
        while (sb2.size() > 0 && sb2[0].due <= cyc) begin
            e = sb2.pop_front();
            chk("qout_L2", if2.qout, e.val);
        end
        while (sb3.size() > 0 && sb3[0].due <= cyc) begin
            e = sb3.pop_front();
            chk("qout_L1_narrow", if3.qout, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drain();
    endtask

    // exp_ovr < 0 takes the read value from the memory model, otherwise from the caller.
    task automatic drive(input bit en, input bit we, input int addr,
                         input logic [DW-1:0] din, input int exp_ovr);
        bit            rdy;
        bit            inr;
        logic [DW-1:0] rv;
        exp_t          e;
        if1.en = en; if1.we = we; if1.addr = AW'(addr); if1.din = din;
        if2.en = en; if2.we = we; if2.addr = AW'(addr); if2.din = din;
        if3.en = en; if3.we = we; if3.addr = AW'(addr); if3.din = din;
        rdy = (cyc >= rdy_cyc);
        inr = (addr < MS);
        if (en && (!rdy || !inr)) m_err = 1'b1;
        if (en && rdy && !we) begin
            rv = '0;
            if (inr) rv = m_mem[addr];
            if (exp_ovr >= 0) rv = DW'(exp_ovr);
            e.val = rv;
            e.due = cyc + 1; sb1.push_back(e); sb3.push_back(e);
            e.due = cyc + 2; sb2.push_back(e);
            if (inr) m_rd++;
        end
        if (en && rdy && we && inr) begin
            m_mem[addr] = din;
            m_wr++;
        end
        if (i_clr) begin
            m_err = 1'b0;
            m_wr  = 0;
            m_rd  = 0;
        end
    endtask

    task automatic cycle(input bit en, input bit we, input int addr, input logic [DW-1:0] din);
        drive(en, we, addr, din, -1);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 0, '0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_err_L1"}, err1, m_err);
        chk({tag, "_err_L2"}, err2, m_err);
        chk({tag, "_err_n"},  err3, m_err);
        chk({tag, "_wcnt_L1"}, wc1, sat(m_wr, CW));
        chk({tag, "_rcnt_L1"}, rc1, sat(m_rd, CW));
        chk({tag, "_wcnt_L2"}, wc2, sat(m_wr, CW));
        chk({tag, "_rcnt_L2"}, rc2, sat(m_rd, CW));
        chk({tag, "_wcnt_n"},  wc3, sat(m_wr, CW3));
        chk({tag, "_rcnt_n"},  rc3, sat(m_rd, CW3));
    endtask

    task automatic reset_assert();
        rst_n   = 1'b0;
        rdy_cyc = 1 << 30;
        sb1.delete(); sb2.delete(); sb3.delete();
        m_err = 1'b0; m_wr = 0; m_rd = 0;
    endtask

    task automatic reset_release();
        rst_n   = 1'b1;
        rdy_cyc = cyc + MS;
        foreach (m_mem[i]) m_mem[i] = '0;
    endtask

    task automatic wait_ready(input string tag, input int c0);
        while (!rdy1 && (cyc - c0) < 2 * MS) cycle(1'b0, 1'b0, 0, '0);
        chk({tag, "_init_len"}, cyc - c0, MS);
        chk({tag, "_ready_L2"}, rdy2, 1'b1);
        chk({tag, "_ready_n"},  rdy3, 1'b1);
    endtask

    initial begin
        int c0;

        vt[0] = '{1'b1, 10,   8'hA5, 8'h00};
        vt[1] = '{1'b0, 10,   8'h00, 8'hA5};
        vt[2] = '{1'b1, 4094, 8'h3C, 8'h00};
        vt[3] = '{1'b0, 4094, 8'h00, 8'h3C};
        vt[4] = '{1'b0, 4095, 8'h00, 8'h00};
        vt[5] = '{1'b1, 4095, 8'hFF, 8'h00};
        vt[6] = '{1'b0, 11,   8'h00, 8'h0B};
        vt[7] = '{1'b0, 50,   8'h00, 8'hEE};

        reset_assert();
        drive(1'b0, 1'b0, 0, '0, -1);
        repeat (3) step();
        chk("rst_qout_L1", if1.qout, 0);
        chk("rst_qout_L2", if2.qout, 0);
        chk("rst_ready", rdy1, 0);
        chk_status("rst");

        // Power-on INIT with a write and a read issued while it runs
        reset_release();
        c0 = cyc;
        idle(10);
        cycle(1'b1, 1'b1, 5, 8'h77);
        cycle(1'b1, 1'b0, 5, '0);
        chk("init_req_err", err1, 1'b1);
        chk("init_req_ready", rdy1, 1'b0);
        chk("init_req_qout_L1", if1.qout, 0);
        chk("init_req_qout_L2", if2.qout, 0);
        wait_ready("por", c0);

        cycle(1'b1, 1'b0, 100, '0);
        cycle(1'b1, 1'b0, 5, '0);
        idle(3);
        chk_status("post_init");
        i_clr = 1'b1; cycle(1'b0, 1'b0, 0, '0); i_clr = 1'b0;
        chk_status("clr0");

        // Burst writes followed by back-to-back reads
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, i, DW'(i));
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, i, '0);
        idle(3);
        chk_status("burst");
        chk("burst_wcnt", wc1, 100);
        chk("burst_rcnt", rc1, 100);
        chk("hold_L1", if1.qout, 99);
        chk("hold_L2", if2.qout, 99);
        cycle(1'b1, 1'b1, 50, 8'hEE);
        idle(2);
        chk("wnc_L1", if1.qout, 99);
        chk("wnc_L2", if2.qout, 99);

        // Table of single accesses including range boundaries
        i_clr = 1'b1; cycle(1'b0, 1'b0, 0, '0); i_clr = 1'b0;
        foreach (vt[k]) begin
            drive(1'b1, vt[k].we, vt[k].addr, vt[k].din, vt[k].we ? -1 : int'(vt[k].exp_q));
            step();
        end
        idle(3);
        chk_status("table");
        chk("table_err", err1, 1'b1);
        chk("table_wcnt", wc1, 2);
        chk("table_rcnt", rc1, 4);
        i_clr = 1'b1; cycle(1'b0, 1'b0, 0, '0); i_clr = 1'b0;
        chk_status("clr1");

        // Clear coinciding with an error and with an accepted read
        i_clr = 1'b1;
        cycle(1'b1, 1'b0, 4095, '0);
        cycle(1'b1, 1'b0, 10, '0);
        i_clr = 1'b0;
        idle(2);
        chk_status("clr_prio");
        chk("clr_prio_err", err1, 1'b0);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 254; i++) cycle(1'b1, 1'b0, i, '0);
        idle(2);
        chk_status("sat_pre");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 20 + i, '0);
        idle(2);
        chk_status("sat");
        chk("sat_rcnt_n", rc3, 8'hFF);
        chk("sat_rcnt_L1", rc1, 257);

        // Reset while a latency-2 read is still in flight
        drive(1'b1, 1'b0, 10, '0, -1);
        step();
        reset_assert();
        drive(1'b0, 1'b0, 0, '0, -1);
        step();
        chk("rst_rd_qout_L1", if1.qout, 0);
        chk("rst_rd_qout_L2", if2.qout, 0);
        chk("rst_rd_ready", rdy1, 0);
        chk_status("rst_rd");

        // Reset pulse in the middle of INIT restarts the sweep
        reset_release();
        idle(1000);
        chk("midinit_ready", rdy1, 0);
        reset_assert();
        step();
        reset_release();
        c0 = cyc;
        chk("pulse_ready", rdy1, 0);
        wait_ready("restart", c0);
        cycle(1'b1, 1'b0, 10, '0);
        cycle(1'b1, 1'b0, 4094, '0);
        idle(3);
        chk_status("final");
        chk("sb_drained", sb1.size() + sb2.size() + sb3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
